// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. It owns PC_F, tolerates
// instruction-memory wait states, and absorbs EX redirects, including redirects that arrive mid-request.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall_F,
   input  logic        PCSrc_E,
   input  logic [31:0] PCTarget_E,
   output logic        IMemReq_F,
   output logic [31:0] IMemAddr_F,
   input  logic [31:0] IMemRdata_F,
   input  logic        IMemValid_F,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PCPlus4_D,
   output logic        Valid_D,
   output logic        FetchBusy_F
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcd_q, pcd_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;

   logic [31:0] target_s;
   logic [31:0] pc_plus4_s;
   logic        accept_s;
   logic        bubble_s;
   logic [31:0] accept_data_s;
   logic        unused_tgt_lsb_s;

   assign target_s         = word_align(PCTarget_E);
   assign pc_plus4_s       = pc_q + 32'd4;
   assign unused_tgt_lsb_s = ^PCTarget_E[1:0];

   // Fetch control: next state, PC, pending redirect target and held instruction
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redir_d       = redir_q;
      buf_d         = buf_q;
      accept_s      = 1'b0;
      bubble_s      = 1'b0;
      accept_data_s = IMemRdata_F;
      case (state_q)
         S_FETCH: begin
            if (PCSrc_E) begin
               bubble_s = 1'b1;
               if (IMemValid_F) begin
                  pc_d = target_s;
               end else begin
                  redir_d = target_s;
                  state_d = S_DRAIN;
               end
            end else if (IMemValid_F) begin
               if (!Stall_F) begin
                  accept_s = 1'b1;
                  pc_d     = pc_plus4_s;
               end else begin
                  buf_d   = IMemRdata_F;
                  state_d = S_HOLD;
               end
            end else if (!Stall_F) begin
               bubble_s = 1'b1;
            end else begin
               bubble_s = 1'b0;
            end
         end
         S_HOLD: begin
            accept_data_s = buf_q;
            if (PCSrc_E) begin
               bubble_s = 1'b1;
               pc_d     = target_s;
               state_d  = S_FETCH;
            end else if (!Stall_F) begin
               accept_s = 1'b1;
               pc_d     = pc_plus4_s;
               state_d  = S_FETCH;
            end else begin
               accept_s = 1'b0;
            end
         end
         S_DRAIN: begin
            // The in-flight response belongs to the squashed path, so it is dropped
            bubble_s = PCSrc_E | ~Stall_F;
            if (IMemValid_F) begin
               pc_d    = PCSrc_E ? target_s : redir_q;
               state_d = S_FETCH;
            end else if (PCSrc_E) begin
               redir_d = target_s;
            end else begin
               redir_d = redir_q;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // IF/ID register next-value selection
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      if (accept_s) begin
         instr_d = accept_data_s;
         pcd_d   = pc_q;
         pcp4_d  = pc_plus4_s;
         valid_d = 1'b1;
      end else if (bubble_s) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State, PC and IF/ID registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         redir_q <= 32'd0;
         buf_q   <= 32'd0;
         instr_q <= NOP_INSTR;
         pcd_q   <= 32'd0;
         pcp4_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         redir_q <= redir_d;
         buf_q   <= buf_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
      end
   end

   assign IMemReq_F   = ~rst & (state_q != S_HOLD);
   assign IMemAddr_F  = pc_q;
   assign FetchBusy_F = (state_q == S_DRAIN) | ((state_q == S_FETCH) & ~IMemValid_F);
   assign Instr_D     = instr_q;
   assign PC_D        = pcd_q;
   assign PCPlus4_D   = pcp4_q;
   assign Valid_D     = valid_q;

   fetch_stage_checker #(
      .NOP_INSTR(NOP_INSTR)
   ) u_checker (
      .clk        (clk),
      .rst        (rst),
      .req_i      (IMemReq_F),
      .addr_i     (IMemAddr_F),
      .mem_valid_i(IMemValid_F),
      .instr_i    (Instr_D),
      .valid_i    (Valid_D)
   );

endmodule

// Run-time invariant checks for the fetch stage: bubble encoding, no request
// under reset, and a stable request address until the response is seen.
module fetch_stage_checker #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic        clk,
   input logic        rst,
   input logic        req_i,
   input logic [31:0] addr_i,
   input logic        mem_valid_i,
   input logic [31:0] instr_i,
   input logic        valid_i
);

   logic        pending_q;
   logic [31:0] prev_addr_q;

   // Remember whether a request was left unanswered in the previous cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= 1'b0;
         prev_addr_q <= 32'd0;
      end else begin
         pending_q   <= req_i & ~mem_valid_i;
         prev_addr_q <= addr_i;
      end
   end

   // Invariant checks sampled on each rising edge
   always_ff @(posedge clk) begin
      if (rst) begin
         a_no_req_in_rst: assert (!req_i);
      end else begin
         a_bubble_is_nop: assert (valid_i || (instr_i == NOP_INSTR));
         if (pending_q) begin
            a_addr_stable: assert (addr_i == prev_addr_q);
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized
// traffic compared against a transaction-level reference model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        Stall_F;
   logic        PCSrc_E;
   logic [31:0] PCTarget_E;
   logic        IMemReq_F;
   logic [31:0] IMemAddr_F;
   logic [31:0] IMemRdata_F;
   logic        IMemValid_F;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic [31:0] PCPlus4_D;
   logic        Valid_D;
   logic        FetchBusy_F;

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(NOP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Stall_F    (Stall_F),
      .PCSrc_E    (PCSrc_E),
      .PCTarget_E (PCTarget_E),
      .IMemReq_F  (IMemReq_F),
      .IMemAddr_F (IMemAddr_F),
      .IMemRdata_F(IMemRdata_F),
      .IMemValid_F(IMemValid_F),
      .Instr_D    (Instr_D),
      .PC_D       (PC_D),
      .PCPlus4_D  (PCPlus4_D),
      .Valid_D    (Valid_D),
      .FetchBusy_F(FetchBusy_F)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        mv;
      logic [31:0] rdata;
      logic        chk_pre;
      logic        req;
      logic [31:0] addr;
      logic        busy;
      logic [31:0] instr;
      logic [31:0] pcd;
      logic [31:0] pcp4;
      logic        valid;
   } vec_t;

   int checks;
   int errors;
   vec_t tbl[$];

   // Reference model: pc, optional held instruction, optional pending redirect, IF/ID contents
   logic [31:0] m_pc, m_buf, m_redir, m_instr, m_pcd, m_pcp4;
   logic        m_have_buf, m_drain, m_valid;

   function automatic vec_t mk(input logic r, input logic st, input logic ps, input logic [31:0] tg,
                               input logic mv, input logic [31:0] rd, input logic rq,
                               input logic [31:0] ad, input logic bz, input logic [31:0] ins,
                               input logic [31:0] pd, input logic [31:0] p4, input logic vd);
      vec_t v;
      v.rst = r; v.stall = st; v.pcsrc = ps; v.tgt = tg; v.mv = mv; v.rdata = rd;
      v.chk_pre = 1'b1; v.req = rq; v.addr = ad; v.busy = bz;
      v.instr = ins; v.pcd = pd; v.pcp4 = p4; v.valid = vd;
      return v;
   endfunction

   task automatic chk(input string tag, input int idx, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] %s: got %h expected %h", tag, idx, name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      rst = v.rst; Stall_F = v.stall; PCSrc_E = v.pcsrc; PCTarget_E = v.tgt;
      IMemValid_F = v.mv; IMemRdata_F = v.rdata;
      #1;
      if (v.chk_pre) begin
         chk(tag, idx, "IMemReq_F", {31'd0, IMemReq_F}, {31'd0, v.req});
         chk(tag, idx, "IMemAddr_F", IMemAddr_F, v.addr);
         chk(tag, idx, "FetchBusy_F", {31'd0, FetchBusy_F}, {31'd0, v.busy});
      end
      @(posedge clk);
      #1;
      chk(tag, idx, "Instr_D", Instr_D, v.instr);
      chk(tag, idx, "PC_D", PC_D, v.pcd);
      chk(tag, idx, "PCPlus4_D", PCPlus4_D, v.pcp4);
      chk(tag, idx, "Valid_D", {31'd0, Valid_D}, {31'd0, v.valid});
      @(negedge clk);
   endtask

   task automatic m_accept(input logic [31:0] d);
      m_instr = d; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
   endtask

   task automatic m_bubble();
      m_instr = NOP; m_valid = 1'b0;
   endtask

   task automatic model_step(input vec_t v);
      logic [31:0] t;
      t = v.tgt & 32'hFFFF_FFFC;
      if (v.rst) begin
         m_pc = 32'd0; m_have_buf = 1'b0; m_drain = 1'b0; m_redir = 32'd0; m_buf = 32'd0;
         m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
      end else if (m_have_buf) begin
         if (v.pcsrc) begin
            m_bubble(); m_pc = t; m_have_buf = 1'b0;
         end else if (!v.stall) begin
            m_accept(m_buf); m_have_buf = 1'b0;
         end
      end else if (m_drain) begin
         if (v.pcsrc || !v.stall) m_bubble();
         if (v.mv) begin
            m_pc = v.pcsrc ? t : m_redir; m_drain = 1'b0;
         end else if (v.pcsrc) begin
            m_redir = t;
         end
      end else begin
         if (v.pcsrc) begin
            m_bubble();
            if (v.mv) m_pc = t;
            else begin m_drain = 1'b1; m_redir = t; end
         end else if (v.mv) begin
            if (!v.stall) m_accept(v.rdata);
            else begin m_buf = v.rdata; m_have_buf = 1'b1; end
         end else if (!v.stall) begin
            m_bubble();
         end
      end
   endtask

   initial begin
      vec_t v;
      checks = 0; errors = 0;
      m_pc = 32'd0; m_buf = 32'd0; m_redir = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0;
      m_have_buf = 1'b0; m_drain = 1'b0; m_valid = 1'b0;
      rst = 1'b1; Stall_F = 1'b0; PCSrc_E = 1'b0; PCTarget_E = 32'd0;
      IMemValid_F = 1'b0; IMemRdata_F = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      //                rst   stall pcsrc tgt            mv    rdata          req   addr           busy  instr          pc_d           pc+4_d         vld
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         1'b0, NOP,           32'h0,         32'h0,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5,        1'b1, 32'h0,         1'b0, 32'hA5,        32'h0,         32'h4,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA1,        1'b1, 32'h4,         1'b0, 32'hA1,        32'h4,         32'h8,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hAD,        1'b1, 32'h8,         1'b0, 32'hAD,        32'h8,         32'hC,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA9,        1'b1, 32'hC,         1'b0, 32'hA9,        32'hC,         32'h10,        1'b1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,         1'b1, 32'h10,        1'b1, NOP,           32'hC,         32'h10,        1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hB5,        1'b1, 32'h10,        1'b0, 32'hB5,        32'h10,        32'h14,        1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hB1,        1'b1, 32'h14,        1'b0, 32'hB1,        32'h14,        32'h18,        1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBD,        1'b1, 32'h18,        1'b0, 32'hBD,        32'h18,        32'h1C,        1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hB9,        1'b1, 32'h1C,        1'b0, 32'hB9,        32'h1C,        32'h20,        1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h20,        1'b1, NOP,           32'h1C,        32'h20,        1'b0));
      // stall while the response returns, then release
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0050_0093, 1'b1, 32'h20,        1'b0, NOP,           32'h1C,        32'h20,        1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h20,        1'b0, NOP,           32'h1C,        32'h20,        1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h20,        1'b0, 32'h0050_0093, 32'h20,        32'h24,        1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h81,        1'b1, 32'h24,        1'b0, 32'h81,        32'h24,        32'h28,        1'b1));
      // three redirects while a request is outstanding; the newest one wins
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h103,       1'b0, 32'h0,         1'b1, 32'h28,        1'b1, NOP,           32'h24,        32'h28,        1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1, 32'h28,        1'b1, NOP,           32'h24,        32'h28,        1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h303,       1'b0, 32'h0,         1'b1, 32'h28,        1'b1, NOP,           32'h24,        32'h28,        1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 32'h28,        1'b1, NOP,           32'h24,        32'h28,        1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h3A5,       1'b1, 32'h300,       1'b0, 32'h3A5,       32'h300,       32'h304,       1'b1));
      // redirect with data present (stall overridden), then PC wrap
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h1111_1111, 1'b1, 32'h304,       1'b0, NOP,           32'h300,       32'h304,       1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h1234_5678, 32'hFFFF_FFFC, 32'h0,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5,        1'b1, 32'h0,         1'b0, 32'hA5,        32'h0,         32'h4,         1'b1));
      // redirect while holding a buffered instruction
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hCAFE,      1'b1, 32'h4,         1'b0, 32'hA5,        32'h0,         32'h4,         1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h500,       1'b0, 32'h0,         1'b0, 32'h4,         1'b0, NOP,           32'h0,         32'h4,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5A5,       1'b1, 32'h500,       1'b0, 32'h5A5,       32'h500,       32'h504,       1'b1));
      // reset in the middle of a drain
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h600,       1'b0, 32'h0,         1'b1, 32'h504,       1'b1, NOP,           32'h500,       32'h504,       1'b0));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h504,       1'b1, NOP,           32'h0,         32'h0,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b1, NOP,           32'h0,         32'h0,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5,        1'b1, 32'h0,         1'b0, 32'hA5,        32'h0,         32'h4,         1'b1));
      // stalled wait state, then redirect racing the response in a drain
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'hA5,        32'h0,         32'h4,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA1,        1'b1, 32'h4,         1'b0, 32'hA1,        32'h4,         32'h8,         1'b1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h700,       1'b0, 32'h0,         1'b1, 32'h8,         1'b1, NOP,           32'h4,         32'h8,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h800,       1'b1, 32'h9999,      1'b1, 32'h8,         1'b1, NOP,           32'h4,         32'h8,         1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8A5,       1'b1, 32'h800,       1'b0, 32'h8A5,       32'h800,       32'h804,       1'b1));

      foreach (tbl[i]) apply(tbl[i], "vec", i);

      // Hand sequence: long stall in HOLD keeps the request low and IF/ID frozen
      v = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7777, 1'b1, 32'h804, 1'b0, 32'h8A5, 32'h800, 32'h804, 1'b1);
      apply(v, "hold", 0);
      for (int k = 1; k < 4; k++) begin
         v = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h804, 1'b0, 32'h8A5, 32'h800, 32'h804, 1'b1);
         apply(v, "hold", k);
      end
      v = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h804, 1'b0, 32'h7777, 32'h804, 32'h808, 1'b1);
      apply(v, "hold", 4);

      // Randomized traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         v.rst     = (i == 0) || ($urandom_range(0, 199) == 0);
         v.stall   = ($urandom_range(0, 3) == 0);
         v.pcsrc   = ($urandom_range(0, 7) == 0);
         v.tgt     = $urandom;
         v.mv      = $urandom_range(0, 1) == 1;
         v.rdata   = $urandom;
         v.chk_pre = (i != 0);
         v.req     = !v.rst && !m_have_buf;
         v.addr    = m_pc;
         v.busy    = m_drain || (!m_have_buf && !v.mv);
         model_step(v);
         v.instr = m_instr; v.pcd = m_pcd; v.pcp4 = m_pcp4; v.valid = m_valid;
         apply(v, "rand", i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns PC_F and issues requests to instruction memory, which may insert wait states.
- Buffers a returned instruction when the pipeline is stalled, and handles EX-stage redirects, including redirects that arrive while a request is in flight.
- Drives Instr_D, PC_D and PCPlus4_D to decode, plus a Valid_D bit.

Parameters:
- RESET_PC, 32'h0000_0000, PC_F value on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on Instr_D when invalid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Stall_F  input  1  hazard-unit stall; holds both PC_F and the IF/ID register.
- PCSrc_E  input  1  redirect request from EX (taken branch or jump).
- PCTarget_E  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- IMemReq_F  output  1  instruction request valid.
- IMemAddr_F  output  32  request address; always equals PC_F.
- IMemRdata_F  input  32  returned instruction word.
- IMemValid_F  input  1  response valid; may be asserted in the same cycle as the request (zero wait) or later. Address is held stable until this is seen.
- Instr_D  output  32  IF/ID instruction.
- PC_D  output  32  IF/ID PC.
- PCPlus4_D  output  32  IF/ID PC+4.
- Valid_D  output  1  IF/ID holds a real instruction.
- FetchBusy_F  output  1  1 when in DRAIN, or in FETCH with IMemValid_F=0.

Behaviour:
- Reset (synchronous, highest priority):
  - PC_F=RESET_PC, state=FETCH, RedirPC=0, Buf=0.
  - Instr_D=NOP_INSTR, PC_D=0, PCPlus4_D=0, Valid_D=0.
  - IMemReq_F=0 in any cycle where rst=1.
  - Reset mid-DRAIN or mid-HOLD abandons all pending state; the memory shares the same rst.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC+4=32'h0.
- Priority within a cycle: rst > PCSrc_E > Stall_F.
- "Accept X" means: IF/ID <= {X, PC_F, PC_F+4, Valid_D=1}; PC_F <= PC_F+4.
- "Bubble" means: IF/ID <= {NOP_INSTR, PC_D unchanged, PCPlus4_D unchanged, Valid_D=0}.
- Every redirect bubbles IF/ID on the same edge; Stall_F is overridden.
- State FETCH (IMemReq_F=1):
  - PCSrc_E & IMemValid_F: discard data; PC_F<=target; stay FETCH.
  - PCSrc_E & !IMemValid_F: RedirPC<=target; go DRAIN.
  - IMemValid_F & !Stall_F: accept IMemRdata_F.
  - IMemValid_F & Stall_F: Buf<=IMemRdata_F; go HOLD; PC_F and IF/ID held.
  - !IMemValid_F & !Stall_F: bubble.
  - !IMemValid_F & Stall_F: hold everything.
- State HOLD (IMemReq_F=0):
  - PCSrc_E: discard Buf; PC_F<=target; go FETCH.
  - !Stall_F: accept Buf; go FETCH.
  - Stall_F: hold.
- State DRAIN (IMemReq_F=1, IMemAddr_F=old PC_F, kept stable until the response arrives):
  - IMemValid_F: discard data; PC_F <= (PCSrc_E ? target : RedirPC); go FETCH.
  - !IMemValid_F & PCSrc_E: RedirPC<=target (newest redirect wins).
  - IF/ID: bubble unless Stall_F; Valid_D stays 0 either way.
- Latency:
  - A zero-wait instruction appears on Instr_D one cycle after its address is on IMemAddr_F.
  - Throughput is 1 instruction per cycle when IMemValid_F is held high and there is no stall.
- Invariant: Valid_D=0 implies Instr_D=NOP_INSTR.

Test Plan:
- Reset then stream: RESET_PC=0, IMemValid_F=1, rdata=addr^32'hA5 → Instr_D shows 0xA5, 0xA1, 0xAD… on successive cycles; PC_D=0,4,8; PCPlus4_D=4,8,12; Valid_D=1 from the 2nd cycle after rst deasserts.
- Wait states: IMemValid_F low for 3 cycles at PC_F=0x10 → 3 bubble cycles (Valid_D=0, Instr_D=0x13, FetchBusy_F=1), then Instr_D=rdata with PC_D=0x10.
- Stall with response: Stall_F=1 in the cycle IMemValid_F returns 0x00500093 at PC 0x20 → state HOLD, IMemReq_F=0, IF/ID unchanged; release Stall_F → Instr_D=0x00500093, PC_D=0x20, next IMemAddr_F=0x24.
- Redirect during wait: PC_F=0x40 pending, PCSrc_E with target 0x103 → IMemAddr_F stays 0x40 until valid, that data is discarded, next IMemAddr_F=0x100; Valid_D=0 throughout.
- Double redirect in DRAIN: targets 0x200 then 0x300 before the response arrives → next fetch at 0x300. Redirect in HOLD → Buf discarded and fetch restarts at the target the next cycle.
- Wrap and reset-mid-op: PC 0xFFFFFFFC accepted → PCPlus4_D=0, next IMemAddr_F=0. Assert rst while in DRAIN → after one clock: state FETCH, PC_F=RESET_PC, Valid_D=0, IMemReq_F=0 during rst.
